alu_cmd_driver: RTL
===================

# alu_cmd_driver

Sequential initiator for the 4-bit ALU datapath. Accepts operation commands over a valid/ready handshake, drives the ALU opcode and operand inputs from registers, and waits one settling cycle. It then samples the ALU result and carry into a result FIFO, which downstream logic drains over a second valid/ready handshake. It sits between the lab's command source (switch/UART front end or testbench) and the combinational ALU.

## Interface
- DEPTH, 4, result FIFO entries; power of two, >= 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command this cycle
- cmd_op  input  2  00 add, 01 sub, 10 shift-left, 11 and
- cmd_a  input  4  operand A
- cmd_b  input  4  operand B
- alu_op  output  2  registered opcode to the ALU
- alu_a  output  4  registered operand A to the ALU
- alu_b  output  4  registered operand B to the ALU
- alu_result  input  4  ALU result
- alu_carry  input  1  ALU carry-out
- rsp_valid  output  1  FIFO head entry valid
- rsp_ready  input  1  consumer takes head entry
- rsp_data  output  4  result at FIFO head
- rsp_carry  output  1  carry at FIFO head
- rsp_op  output  2  opcode echo at FIFO head
- rsp_zero, rsp_ovf  output  1 each  flags; present only with ALU_DRV_FLAGS_EN

## Operation
- FSM states: IDLE, DRIVE, CAPT. Reset state is IDLE.
- IDLE:
  - cmd_ready = (fifo_count < DEPTH).
  - On cmd_valid && cmd_ready: load alu_op/alu_a/alu_b from cmd_*; go to DRIVE.
- DRIVE: settling cycle; cmd_ready = 0; go to CAPT.
- CAPT:
  - cmd_ready = 0.
  - Push {alu_result, carry, alu_op} into the FIFO; go to IDLE.
- Carry rule:
  - carry = alu_carry for op 00/01.
  - carry is forced to 0 for op 10/11.
- Expected ALU arithmetic, for checking:
  - add: 4-bit a+b with carry-out.
  - sub: a + ~b + 1; carry = 1 means no borrow.
  - shift: a << b truncated to 4 bits, so b >= 4 gives 0.
  - and: bitwise AND.
- alu_* outputs hold their last values outside an operation.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read/write pointers, which wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - rsp_valid = (count != 0). rsp_* show the head entry.
  - Pop on rsp_valid && rsp_ready.
- Space guarantee: only one command is in flight, and admission requires count < DEPTH. A CAPT push therefore always has space; no overflow path exists.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
- rsp_ready while the FIFO is empty: ignored; pointers do not move.
- cmd_valid outside IDLE: ignored, not latched.

## Timing
- Reset values:
  - state IDLE.
  - alu_op/alu_a/alu_b = 0.
  - FIFO pointers and count = 0.
  - rsp_valid = 0. cmd_ready = 1 from the first cycle after reset release.
- Reset asserted mid-operation: in-flight command discarded, FIFO flushed, all outputs return to reset values immediately (asynchronous).
- Latency and throughput:
  - Command accepted at edge N.
  - alu_* outputs valid after edge N.
  - Result sampled at edge N+2.
  - If the FIFO was empty, rsp_valid rises after edge N+2.
  - Throughput: one command per 3 cycles.
- A full FIFO holds cmd_ready low in IDLE until a pop occurs. cmd_ready rises the cycle after that pop.
- rsp_* outputs are stable while rsp_valid && !rsp_ready.

## Configuration
- ALU_DRV_FLAGS_EN defined:
  - FIFO entry widens from 7 to 9 bits.
  - Adds rsp_zero = (result == 0).
  - Adds rsp_ovf = signed overflow for add/sub, computed from the sign bits of alu_a, alu_b (inverted for sub) and the result. rsp_ovf is 0 for ops 10/11.
- ALU_DRV_FLAGS_EN undefined: rsp_zero and rsp_ovf ports and their storage are absent.

## Test plan
- Reset, then add a=9 b=8 -> after 3 cycles rsp_data=1, rsp_carry=1, rsp_op=00; with flags enabled, rsp_zero=0, rsp_ovf=1.
- Sub a=5 b=3 -> rsp_data=2, carry=1. Sub a=3 b=5 -> rsp_data=14, carry=0. Sub a=3 b=3 -> rsp_data=0, rsp_zero=1.
- Shift a=3 b=2 -> 12. Shift a=3 b=5 -> 0. And a=12 b=10 -> 8. Carry is 0 for all three.
- Hold rsp_ready=0 and issue 5 commands -> after the 4th capture cmd_ready stays low. One pop -> 5th command accepted. Results drain in order, and rsp_* stay stable while stalled.
- Drain and refill with rsp_ready=1 throughout -> simultaneous push/pop across pointer wrap, no loss or duplication over 20 commands.
- Assert rst_n in DRIVE with 2 entries queued -> rsp_valid=0, alu_*=0, cmd_ready=1 after release, and no stale result appears.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: sequential initiator for the 4-bit combinational ALU.
//
// Accepts a command (op, a, b) over a valid/ready handshake and registers it onto the ALU inputs.
// It then waits one settling cycle and captures {result, carry, op} into a small circular result
// FIFO. Downstream logic drains the FIFO over a second valid/ready handshake.
//
// Optional feature macro: ALU_DRV_FLAGS_EN
//   When defined, each FIFO entry also carries a zero flag and a signed-overflow flag, and the
//   rsp_zero_o / rsp_ovf_o ports exist.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid_i        command present
//   cmd_ready_o        command can be accepted this cycle
//   cmd_op_i           00 add, 01 sub, 10 shift-left, 11 and
//   cmd_a_i, cmd_b_i   operands
//   alu_op_o           registered opcode to the ALU
//   alu_a_o, alu_b_o   registered operands to the ALU
//   alu_result_i       ALU result
//   alu_carry_i        ALU carry-out
//   rsp_valid_o        FIFO head valid
//   rsp_ready_i        consumer takes head entry
//   rsp_data_o         head result
//   rsp_carry_o        head carry (forced to 0 for shift/and)
//   rsp_op_o           head opcode echo
//   rsp_zero_o         head zero flag (ALU_DRV_FLAGS_EN only)
//   rsp_ovf_o          head signed overflow flag (ALU_DRV_FLAGS_EN only)
module alu_cmd_driver #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [3:0] cmd_a_i,
  input  logic [3:0] cmd_b_i,
  output logic [1:0] alu_op_o,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  input  logic [3:0] alu_result_i,
  input  logic       alu_carry_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [3:0] rsp_data_o,
  output logic       rsp_carry_o,
`ifdef ALU_DRV_FLAGS_EN
  output logic       rsp_zero_o,
  output logic       rsp_ovf_o,
`endif
  output logic [1:0] rsp_op_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
`ifdef ALU_DRV_FLAGS_EN
  localparam int unsigned EntW = 9;
`else
  localparam int unsigned EntW = 7;
`endif

  typedef enum logic [1:0] {StIdle, StDrive, StCapt} state_e;

  state_e            state_q;
  logic [1:0]        alu_op_q;
  logic [3:0]        alu_a_q;
  logic [3:0]        alu_b_q;

  logic [EntW-1:0]   mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic              accept;
  logic              push;
  logic              pop;
  logic              carry_sel;
  logic [EntW-1:0]   push_entry;
  logic [EntW-1:0]   head_entry;

  // Admission is gated on free space, so the single in-flight command always has a slot at capture.
  assign cmd_ready_o = (state_q == StIdle) && (count_q < CntW'(Depth));
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign push        = (state_q == StCapt);
  assign rsp_valid_o = (count_q != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;

  // Shift and AND have no meaningful carry.
  assign carry_sel = alu_op_q[1] ? 1'b0 : alu_carry_i;

`ifdef ALU_DRV_FLAGS_EN
  logic zero_flag;
  logic b_sign_eff;
  logic ovf_flag;

  assign zero_flag  = (alu_result_i == 4'd0);
  // Subtraction adds ~b, so the effective B sign is inverted.
  assign b_sign_eff = alu_op_q[0] ? ~alu_b_q[3] : alu_b_q[3];
  assign ovf_flag   = ~alu_op_q[1] && (alu_a_q[3] == b_sign_eff) &&
                      (alu_result_i[3] != alu_a_q[3]);
  assign push_entry = {ovf_flag, zero_flag, alu_result_i, carry_sel, alu_op_q};
`else
  assign push_entry = {alu_result_i, carry_sel, alu_op_q};
`endif

  // Command FSM with registered ALU drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      alu_op_q <= 2'd0;
      alu_a_q  <= 4'd0;
      alu_b_q  <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            alu_op_q <= cmd_op_i;
            alu_a_q  <= cmd_a_i;
            alu_b_q  <= cmd_b_i;
            state_q  <= StDrive;
          end
        end
        StDrive: state_q <= StCapt;
        StCapt:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Result FIFO; pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head_entry  = mem_q[rd_ptr_q];
  assign rsp_op_o    = head_entry[1:0];
  assign rsp_carry_o = head_entry[2];
  assign rsp_data_o  = head_entry[6:3];
`ifdef ALU_DRV_FLAGS_EN
  assign rsp_zero_o  = head_entry[7];
  assign rsp_ovf_o   = head_entry[8];
`endif

  assign alu_op_o = alu_op_q;
  assign alu_a_o  = alu_a_q;
  assign alu_b_o  = alu_b_q;

endmodule
